pipeline_processor: RTL and testbench

Four-stage in-order 8-bit pipelined processor: fetch (IF), decode/register-read (ID), execute (EX) and write-back (WB). It executes a fixed 16-word built-in program from an internal instruction ROM against an 8×8-bit register file. It is the top-level compute block of the design. Only clock and reset are driven externally; write-back activity is exposed on debug outputs for observation.

---
 rtl/pipeline_processor.sv | 201 ++++++++++++++++++++
 tb/tb_pipeline_processor.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/pipeline_processor.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_processor
// Purpose  : Four-stage in-order 8-bit pipelined processor (IF, ID, EX, WB).
//            It runs a fixed 16-word built-in program from an internal ROM
//            against an 8 x 8-bit register file. Write-back activity is
//            exposed on debug outputs.
// Ports    : clk     - system clock, rising-edge active
//            reset   - asynchronous reset, active low
//            pc      - current fetch address
//            wb_en   - EX/WB holds a register-writing instruction (rd != 0)
//            wb_addr - destination register of the EX/WB instruction
//            wb_data - result held in the EX/WB stage
// Options  : PIPE_FORWARD_EN - when defined, the EX/WB result is bypassed
//            into EX operands. When undefined, distance-1 dependences read
//            stale register values.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_processor (
    input  logic       clk,
    input  logic       reset,
    output logic [3:0] pc,
    output logic       wb_en,
    output logic [2:0] wb_addr,
    output logic [7:0] wb_data
);

    localparam logic [3:0] c_OP_ADD  = 4'd1;
    localparam logic [3:0] c_OP_SUB  = 4'd2;
    localparam logic [3:0] c_OP_AND  = 4'd3;
    localparam logic [3:0] c_OP_OR   = 4'd4;
    localparam logic [3:0] c_OP_XOR  = 4'd5;
    localparam logic [3:0] c_OP_LI   = 4'd6;
    localparam logic [3:0] c_OP_ADDI = 4'd7;

    // Pipeline state
    logic [3:0]  r_pc;
    logic [15:0] r_ifid_instr;

    logic [3:0]  r_idex_op;
    logic [2:0]  r_idex_rd;
    logic [7:0]  r_idex_a;
    logic [7:0]  r_idex_b;
    logic [7:0]  r_idex_imm8;
`ifdef PIPE_FORWARD_EN
    logic [2:0]  r_idex_rs1;
    logic [2:0]  r_idex_rs2;
`endif

    logic        r_exwb_en;
    logic [2:0]  r_exwb_rd;
    logic [7:0]  r_exwb_data;

    logic [7:0]  r_regs [8];

    // Combinational signals
    logic [15:0] w_rom_instr;
    logic [2:0]  w_id_rs1;
    logic [2:0]  w_id_rs2;
    logic [7:0]  w_id_a;
    logic [7:0]  w_id_b;
    logic [7:0]  w_ex_a;
    logic [7:0]  w_ex_b;
    logic [7:0]  w_ex_result;
    logic        w_ex_wr;

    // ------------------------------------------------------------------
    // Instruction ROM: addresses 6..15 hold NOP (all zeros).
    // LI uses bits [8:0] as immediate field, so bit 8 is encoded as 0.
    // ------------------------------------------------------------------
    always_comb begin
        w_rom_instr = 16'h0000;
        case (r_pc)
            4'd0:    w_rom_instr = {c_OP_LI,  3'd1, 9'd5};               // LI  r1,5
            4'd1:    w_rom_instr = {c_OP_LI,  3'd2, 9'd3};               // LI  r2,3
            4'd2:    w_rom_instr = {c_OP_ADD, 3'd3, 3'd1, 3'd2, 3'd0};   // ADD r3,r1,r2
            4'd3:    w_rom_instr = {c_OP_SUB, 3'd4, 3'd3, 3'd1, 3'd0};   // SUB r4,r3,r1
            4'd4:    w_rom_instr = {c_OP_AND, 3'd5, 3'd3, 3'd4, 3'd0};   // AND r5,r3,r4
            4'd5:    w_rom_instr = {c_OP_OR,  3'd6, 3'd3, 3'd4, 3'd0};   // OR  r6,r3,r4
            default: w_rom_instr = 16'h0000;
        endcase
    end

    // ------------------------------------------------------------------
    // Decode / register read. r0 reads zero; a register being written by
    // EX/WB in this same cycle is taken from EX/WB (write-through), which
    // covers distance-2 dependences.
    // ------------------------------------------------------------------
    assign w_id_rs1 = r_ifid_instr[8:6];
    assign w_id_rs2 = r_ifid_instr[5:3];

    always_comb begin
        w_id_a = r_regs[w_id_rs1];
        if (w_id_rs1 == 3'd0) begin
            w_id_a = 8'h00;
        end else if (r_exwb_en && (r_exwb_rd == w_id_rs1)) begin
            w_id_a = r_exwb_data;
        end
    end

    always_comb begin
        w_id_b = r_regs[w_id_rs2];
        if (w_id_rs2 == 3'd0) begin
            w_id_b = 8'h00;
        end else if (r_exwb_en && (r_exwb_rd == w_id_rs2)) begin
            w_id_b = r_exwb_data;
        end
    end

    // ------------------------------------------------------------------
    // Execute. r_exwb_en already implies rd != 0, so the bypass never
    // substitutes a value for r0.
    // ------------------------------------------------------------------
    always_comb begin
        w_ex_a = r_idex_a;
        w_ex_b = r_idex_b;
`ifdef PIPE_FORWARD_EN
        if (r_exwb_en && (r_exwb_rd == r_idex_rs1)) begin
            w_ex_a = r_exwb_data;
        end
        if (r_exwb_en && (r_exwb_rd == r_idex_rs2)) begin
            w_ex_b = r_exwb_data;
        end
`endif
    end

    always_comb begin
        w_ex_result = 8'h00;
        w_ex_wr     = 1'b0;
        case (r_idex_op)
            c_OP_ADD:  begin w_ex_result = w_ex_a + w_ex_b;  w_ex_wr = 1'b1; end
            c_OP_SUB:  begin w_ex_result = w_ex_a - w_ex_b;  w_ex_wr = 1'b1; end
            c_OP_AND:  begin w_ex_result = w_ex_a & w_ex_b;  w_ex_wr = 1'b1; end
            c_OP_OR:   begin w_ex_result = w_ex_a | w_ex_b;  w_ex_wr = 1'b1; end
            c_OP_XOR:  begin w_ex_result = w_ex_a ^ w_ex_b;  w_ex_wr = 1'b1; end
            c_OP_LI:   begin w_ex_result = r_idex_imm8;      w_ex_wr = 1'b1; end
            c_OP_ADDI: begin
                w_ex_result = w_ex_a + {2'b00, r_idex_imm8[5:0]};
                w_ex_wr     = 1'b1;
            end
            default:   begin w_ex_result = 8'h00;            w_ex_wr = 1'b0; end
        endcase
        // Writes to r0 are discarded and never flagged.
        if (r_idex_rd == 3'd0) begin
            w_ex_wr = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Pipeline registers and register file.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc         <= 4'd0;
            r_ifid_instr <= 16'h0000;
            r_idex_op    <= 4'd0;
            r_idex_rd    <= 3'd0;
            r_idex_a     <= 8'h00;
            r_idex_b     <= 8'h00;
            r_idex_imm8  <= 8'h00;
`ifdef PIPE_FORWARD_EN
            r_idex_rs1   <= 3'd0;
            r_idex_rs2   <= 3'd0;
`endif
            r_exwb_en    <= 1'b0;
            r_exwb_rd    <= 3'd0;
            r_exwb_data  <= 8'h00;
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= 8'h00;
            end
        end else begin
            r_pc         <= r_pc + 4'd1;
            r_ifid_instr <= w_rom_instr;

            r_idex_op    <= r_ifid_instr[15:12];
            r_idex_rd    <= r_ifid_instr[11:9];
            r_idex_a     <= w_id_a;
            r_idex_b     <= w_id_b;
            r_idex_imm8  <= r_ifid_instr[7:0];
`ifdef PIPE_FORWARD_EN
            r_idex_rs1   <= w_id_rs1;
            r_idex_rs2   <= w_id_rs2;
`endif

            r_exwb_en    <= w_ex_wr;
            r_exwb_rd    <= r_idex_rd;
            r_exwb_data  <= w_ex_result;

            if (r_exwb_en) begin
                r_regs[r_exwb_rd] <= r_exwb_data;
            end
        end
    end

    assign pc      = r_pc;
    assign wb_en   = r_exwb_en;
    assign wb_addr = r_exwb_rd;
    assign wb_data = r_exwb_data;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_processor.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_processor
// Purpose  : Directed self-checking bench for pipeline_processor. Expected
//            values are hand-derived from the built-in program; build with
//            PIPE_FORWARD_EN defined to select the forwarding expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_processor;

    logic       clk;
    logic       reset;
    logic [3:0] pc;
    logic       wb_en;
    logic [2:0] wb_addr;
    logic [7:0] wb_data;

    int n_cmp = 0;
    int n_err = 0;

    pipeline_processor u_dut (
        .clk     (clk),
        .reset   (reset),
        .pc      (pc),
        .wb_en   (wb_en),
        .wb_addr (wb_addr),
        .wb_data (wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef PIPE_FORWARD_EN
    localparam logic [7:0] c_EXP_E5 = 8'd8;
    localparam logic [7:0] c_EXP_E6 = 8'd3;
    localparam logic [7:0] c_EXP_E8 = 8'd11;
`else
    localparam logic [7:0] c_EXP_E5 = 8'd5;
    localparam logic [7:0] c_EXP_E6 = 8'hFB;
    localparam logic [7:0] c_EXP_E8 = 8'hFF;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pc",      32'(pc),      32'd0);
        check("rst_wb_en",   32'(wb_en),   32'd0);
        check("rst_wb_addr", 32'(wb_addr), 32'd0);
        check("rst_wb_data", 32'(wb_data), 32'd0);

        @(negedge clk);
        reset = 1'b1;

        edges(1);                               // edge 1
        check("e1_pc",    32'(pc),    32'd1);
        check("e1_wb_en", 32'(wb_en), 32'd0);

        edges(2);                               // edge 3: LI r1,5
        check("e3_wb_en",   32'(wb_en),   32'd1);
        check("e3_wb_addr", 32'(wb_addr), 32'd1);
        check("e3_wb_data", 32'(wb_data), 32'd5);

        edges(1);                               // edge 4: LI r2,3
        check("e4_wb_addr", 32'(wb_addr), 32'd2);
        check("e4_wb_data", 32'(wb_data), 32'd3);

        edges(1);                               // edge 5: ADD r3
        check("e5_wb_en",   32'(wb_en),   32'd1);
        check("e5_wb_addr", 32'(wb_addr), 32'd3);
        check("e5_wb_data", 32'(wb_data), 32'(c_EXP_E5));

        edges(1);                               // edge 6: SUB r4
        check("e6_wb_addr", 32'(wb_addr), 32'd4);
        check("e6_wb_data", 32'(wb_data), 32'(c_EXP_E6));

        edges(1);                               // edge 7: AND r5
        check("e7_wb_addr", 32'(wb_addr), 32'd5);
`ifdef PIPE_FORWARD_EN
        check("e7_wb_data", 32'(wb_data), 32'd0);
`endif

        edges(1);                               // edge 8: OR r6
        check("e8_wb_addr", 32'(wb_addr), 32'd6);
        check("e8_wb_data", 32'(wb_data), 32'(c_EXP_E8));

        for (int e = 9; e <= 15; e++) begin     // NOP slots 6..12
            edges(1);
            check($sformatf("e%0d_nop_wb_en", e), 32'(wb_en), 32'd0);
        end

        edges(1);                               // edge 16
        check("e16_pc_wrap", 32'(pc), 32'd0);

        edges(3);                               // edge 19: LI r1 again
        check("e19_wb_addr", 32'(wb_addr), 32'd1);
        check("e19_wb_data", 32'(wb_data), 32'd5);

        edges(2);                               // edge 21: ADD r3, second pass
        check("e21_wb_addr", 32'(wb_addr), 32'd3);
        check("e21_wb_data", 32'(wb_data), 32'd8);

        // Restart cleanly and assert reset between edges 5 and 6.
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        edges(5);
        check("r5_wb_addr", 32'(wb_addr), 32'd3);
        #2;
        reset = 1'b0;
        #1;
        check("async_pc",      32'(pc),      32'd0);
        check("async_wb_en",   32'(wb_en),   32'd0);
        check("async_wb_addr", 32'(wb_addr), 32'd0);
        check("async_wb_data", 32'(wb_data), 32'd0);

        edges(1);
        check("held_pc", 32'(pc), 32'd0);

        @(negedge clk);
        reset = 1'b1;
        edges(1);
        check("rr1_pc", 32'(pc), 32'd1);
        edges(2);
        check("rr3_wb_addr", 32'(wb_addr), 32'd1);
        check("rr3_wb_data", 32'(wb_data), 32'd5);
        edges(2);
        // Registers must have been cleared: the first-pass result repeats.
        check("rr5_wb_addr", 32'(wb_addr), 32'd3);
        check("rr5_wb_data", 32'(wb_data), 32'(c_EXP_E5));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
